// File: rtl/stream_mux_4to1_pkg.sv
// Shared types and constants for the 4-input packet-granular stream collector.
package stream_mux_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_t;

  // Index of the set bit of a one-hot vector; zero when the vector is empty.
  function automatic logic [SEL_W-1:0] onehot_idx(input logic [N_IN-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (oh[i]) onehot_idx = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/stream_mux_4to1_if.sv
// Four valid/ready input streams plus the merged, source-tagged output stream.
interface stream_mux_4to1_if #(
  parameter int DATA_W = 8
);
  import stream_mux_pkg::*;

  logic [N_IN-1:0]        in_valid;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_last;
  logic [N_IN-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   out_last;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface

// File: rtl/stream_mux_4to1_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter_4
  import stream_mux_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = ptr + SEL_W'(k);
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_4to1.sv
// Merges four byte streams into one; round-robin per packet, registered output tagged with source.
module stream_mux_4to1
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  stream_mux_4to1_if.slave bus
);

  mux_state_t       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] owner, owner_nxt;

  logic [N_IN-1:0]  rr_gnt;
  logic [N_IN-1:0]  grant;
  logic             can_accept;
  logic             accept;
  logic [SEL_W-1:0] sel_g;
  logic [DATA_W-1:0] data_g;
  logic             last_g;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic [SEL_W-1:0]  sel_p1;

  rr_arbiter_4 u_arb (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  assign can_accept   = !vld_p1 || bus.out_ready;
  // Gating with rst_n keeps in_ready low for the whole reset, not just after the first edge.
  assign bus.in_ready = (can_accept && rst_n) ? grant : '0;
  assign accept       = |bus.in_ready;
  assign sel_g        = onehot_idx(grant);
  assign data_g       = bus.in_data[int'(sel_g)*DATA_W +: DATA_W];
  assign last_g       = bus.in_last[sel_g];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (last_g) begin
            ptr_nxt = sel_g + SEL_W'(1);
          end else begin
            state_nxt = LOCKED;
            owner_nxt = sel_g;
          end
        end
        LOCKED: begin
          if (last_g) begin
            state_nxt = IDLE;
            ptr_nxt   = owner + SEL_W'(1);
          end
        end
      endcase
    end
  end

  // While locked, a stalled owner still blocks every other requester.
  always_comb begin
    grant = '0;
    unique case (state)
      IDLE:   grant = rr_gnt;
      LOCKED: grant = bus.in_valid[owner] ? (N_IN'(1) << owner) : '0;
    endcase
  end

  // ---- p1: single-entry output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      sel_p1  <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_g;
      last_p1 <= last_g;
      sel_p1  <= sel_g;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_sel   = sel_p1;

endmodule

// File: doc/stream_mux_4to1.md
# stream_mux_4to1

Merges four valid/ready byte streams into one output stream. It is the collecting counterpart of the 1-to-4 demux, used where four producers share one downstream consumer. Arbitration is round-robin at packet granularity: once an input wins, it keeps the grant until its `last` beat. The output is registered, and each beat is tagged with the index of its source.

## Interface
Parameters:
- `DATA_W`, default 8: width of each data beat.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  4  per-input beat valid; bit i belongs to input i.
- `in_data`  in  4*DATA_W  input i occupies bits [i*DATA_W +: DATA_W].
- `in_last`  in  4  per-input end-of-packet marker.
- `in_ready`  out  4  per-input accept; at most one bit high in any cycle.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DATA_W  output beat.
- `out_last`  out  1  end-of-packet, copied from the source input.
- `out_sel`  out  2  index of the input that produced the current beat.
- `out_ready`  in  1  downstream accept.

## Operation
- **Handshakes.** A beat transfers on a port when valid and ready are both high at a clock edge.
- **Input valids.** `in_valid[i]` must not drop before its beat is accepted.
- **Output valid.** `out_valid` does not depend on `out_ready`.
- **Output register.** A single-entry output register holds the current beat. `can_accept = !out_valid || out_ready`.
- **Grant.** `in_ready[i] = can_accept && grant[i]`. `grant` is one-hot or zero, and is combinational from state, pointer and `in_valid`.
- **State machine.** Two states, IDLE and LOCKED, with a 2-bit `owner` and a 2-bit round-robin pointer `ptr`.
- **IDLE:**
  - `grant` goes to the first requesting input at or after `ptr`, searching ptr, ptr+1, … modulo 4. It is zero when no input is valid.
  - On an accepted beat from input g with `in_last=0`: go to LOCKED and set `owner=g`.
  - On an accepted beat with `in_last=1` (single-beat packet): stay in IDLE and set `ptr=g+1` (wraps 3→0).
- **LOCKED:**
  - `grant` goes to `owner` only, and only if `in_valid[owner]`. Other inputs are stalled even when the owner is idle.
  - On an accepted beat from the owner with `in_last=1`: go to IDLE and set `ptr=owner+1` (wraps).
- **Output register load.** Every accepted input beat loads `out_data`, `out_last` and `out_sel` in the same edge, and sets `out_valid=1`.
- **Output register drain.** If the output beat is consumed and no new beat is accepted, `out_valid` goes to 0. Data fields hold their last value.
- **Simultaneous drain and fill.** When the output is drained and a new beat is accepted in the same cycle, the register loads the new beat and `out_valid` stays 1. Back-to-back throughput is one beat per cycle.
- **Arithmetic.** `ptr` and `owner` arithmetic is modulo 4 (2-bit wrap). There is no other arithmetic.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`.
  - Internal: state IDLE, `ptr=0`, `owner=0`.
  - `in_ready=0` while `rst_n` is low.
- **Reset mid-packet.** Asserting reset mid-packet drops the lock and any buffered beat immediately, without waiting for a clock.
- **Latency.** One cycle from the input handshake to `out_valid`.
- **Combinational paths.**
  - `in_ready` has a combinational path from `out_ready` and `in_valid`.
  - There is no combinational path from any input to `out_valid`, `out_data`, `out_last` or `out_sel`.
- **Output stall.** `out_valid=1` with `out_ready=0` holds every output field stable, and `in_ready` is all zero.
- **Cost of a rotation.** The grant rotates only at packet boundaries. A single-beat packet from each of four requesters takes 4 consecutive cycles with no bubbles.

## Structure
- **Package `stream_mux_pkg`:**
  - `N_IN=4`, `SEL_W=2`.
  - State enum `mux_state_t` {IDLE, LOCKED}.
- **Sub-module `rr_arbiter_4`:**
  - Inputs: `req[3:0]` and `ptr[1:0]`.
  - Output: one-hot `gnt[3:0]`, which is the first request at or after `ptr`.
  - Purely combinational, and reusable by other collectors in the team.
- **Top level.** Holds the state register, the pointer/owner registers, the lock override on `grant`, and the output register.

## Test plan
1. **Reset.** Apply reset, then release it with `in_valid=0`. Required: all outputs 0 and `in_ready=4'b0000` for 5 cycles.
2. **Round-robin order.** Drive `in_valid=4'b1111` with `in_last=4'b1111`, data 0xA0..0xA3 on inputs 0..3, and `out_ready=1`. Required: outputs A0, A1, A2, A3, A0 with `out_sel` 0, 1, 2, 3, 0 on consecutive cycles.
3. **Packet lock.** Input 2 sends a 3-beat packet 0x11, 0x12, 0x13, with `last` on the third beat. Input 0 is valid throughout. Required: `out_sel=2` for 3 beats, then 0. `in_ready[0]` stays 0 until after 0x13 is accepted, including a cycle where input 2 deasserts valid mid-packet.
4. **Backpressure.** Send beat 0x55 from input 1, then hold `out_ready=0` for 4 cycles. Required: `out_valid=1`, `out_data=0x55` and `out_sel=1` stay stable, and `in_ready=0` throughout. Release `out_ready`: 0x55 transfers on that edge and the next pending beat loads in the same edge.
5. **Pointer wrap.** Set `ptr=3` after a packet from input 2. Then requests on inputs 0 and 3 arrive together. Required: input 3 is served first, then input 0.
6. **Reset mid-packet.** Input 1 is locked after beat 1 of 3, and `out_valid=1`. Assert `rst_n=0` between clock edges. Required: `out_valid` drops immediately. After release, input 3's request is granted with `ptr=0` ordering.
